// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard/debug requests in, stage enables and status out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             jump;
  logic             ex_multi;
  logic             ex_done;
  logic             dbg_halt_req;
  logic             dbg_step_req;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             halted;
  logic             step_ack;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [2:0]       state;

  modport master (
    output jump, ex_multi, ex_done, dbg_halt_req, dbg_step_req,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush,
    input  halted, step_ack, timeout, stall_cnt, state
  );

  modport slave (
    input  jump, ex_multi, ex_done, dbg_halt_req, dbg_step_req,
    output pc_en, if_id_en, if_id_flush, id_ex_flush,
    output halted, step_ack, timeout, stall_cnt, state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: jump flush, multi-cycle EX wait with timeout, debug halt/step.
// Stage enables/flushes are decoded combinationally; all status outputs are registered.
module pipe_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    FLUSH   = 3'd1,
    WAIT_EX = 3'd2,
    HALT    = 3'd3,
    STEP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_q;
  logic              step_prev;
  logic              halted_q;
  logic              step_ack_q;
  logic              timeout_q;
  logic              pc_en, if_id_en, if_id_flush, id_ex_flush;
  logic              wait_expired;

  // Next-state and stage-control decode; reset overrides to a frozen, flushed pipe.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    wait_expired = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.jump) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = FLUSH;
        end else if (bus.ex_multi) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          state_d  = WAIT_EX;
        end else if (bus.dbg_halt_req) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = HALT;
        end
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        state_d     = RUN;
      end
      WAIT_EX: begin
        // A jump can only resolve once the multi-cycle op retires.
        if (bus.ex_done && bus.jump) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = FLUSH;
        end else begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          if (bus.ex_done) begin
            state_d = RUN;
          end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
            wait_expired = 1'b1;
            state_d      = RUN;
          end
        end
      end
      HALT: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        if (!bus.dbg_halt_req) begin
          state_d = RUN;
        end else if (bus.dbg_step_req && !step_prev) begin
          state_d = STEP;
        end
      end
      STEP: begin
        // A jump during the step re-enters HALT via FLUSH and RUN.
        if (bus.jump) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = FLUSH;
        end else begin
          state_d = HALT;
        end
      end
      default: state_d = RUN;
    endcase
    if (!rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // State register, wait/stall counters and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt   <= '0;
      stall_q    <= '0;
      step_prev  <= 1'b0;
      halted_q   <= 1'b0;
      step_ack_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_prev  <= bus.dbg_step_req;
      halted_q   <= (state_d == HALT);
      step_ack_q <= (state_q == STEP);
      wait_cnt   <= (state_q == WAIT_EX) ? wait_cnt + 1'b1 : '0;
      if (wait_expired) timeout_q <= 1'b1;
      if (!pc_en && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.halted      = halted_q;
  assign bus.step_ack    = step_ack_q;
  assign bus.timeout     = timeout_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_ctrl;

  localparam int TO = 4;
  localparam int CW = 6;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state (mode numbers are the externally visible state codes)
  int m_mode, m_wait, m_stall, e_next;
  bit m_to, m_ack, m_halted, m_sprev;
  bit tj, e_pc, e_iff, e_idf;

  task automatic set_in(input logic j, input logic m, input logic d, input logic h, input logic s);
    @(negedge clk);
    bus.jump = j; bus.ex_multi = m; bus.ex_done = d; bus.dbg_halt_req = h; bus.dbg_step_req = s;
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_stall = 0; m_to = 0; m_ack = 0; m_halted = 0; m_sprev = 0;
  endtask

  // What the pipe should do this cycle, from the rules for each mode.
  task automatic model_eval(input bit j, input bit m, input bit d, input bit h, input bit s);
    tj    = ((m_mode == 0 || m_mode == 4) && j) || (m_mode == 2 && j && d);
    e_pc  = tj || m_mode == 1 || m_mode == 4 || (m_mode == 0 && !m && !h);
    e_iff = tj || m_mode == 1;
    e_idf = tj || m_mode == 3 || (m_mode == 0 && !m && h);
    if (tj) e_next = 1;
    else if (m_mode == 0) e_next = m ? 2 : (h ? 3 : 0);
    else if (m_mode == 1) e_next = 0;
    else if (m_mode == 2) e_next = (d || m_wait == TO) ? 0 : 2;
    else if (m_mode == 3) e_next = !h ? 0 : ((s && !m_sprev) ? 4 : 3);
    else e_next = 3;
  endtask

  task automatic model_commit(input bit d, input bit s);
    if (m_mode == 2 && !d && m_wait == TO) m_to = 1;
    m_ack    = (m_mode == 4);
    m_halted = (e_next == 3);
    m_wait   = (m_mode == 2) ? m_wait + 1 : 0;
    if (!e_pc && m_stall < SAT) m_stall++;
    m_sprev  = s;
    m_mode   = e_next;
  endtask

  task automatic test_reset();
    bus.jump = 1; bus.ex_multi = 1; bus.ex_done = 0; bus.dbg_halt_req = 1; bus.dbg_step_req = 1;
    rst = 0;
    #12;
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", bus.state); end
    total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL rst_pc_en got=%b want=0", bus.pc_en); end
    total++; if (bus.if_id_en !== 1'b0) begin bad++; $display("FAIL rst_if_id_en got=%b want=0", bus.if_id_en); end
    total++; if (bus.if_id_flush !== 1'b1) begin bad++; $display("FAIL rst_if_id_flush got=%b want=1", bus.if_id_flush); end
    total++; if (bus.id_ex_flush !== 1'b1) begin bad++; $display("FAIL rst_id_ex_flush got=%b want=1", bus.id_ex_flush); end
    total++; if ({bus.halted, bus.step_ack, bus.timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {bus.halted, bus.step_ack, bus.timeout}); end
    total++; if (bus.stall_cnt !== 6'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", bus.stall_cnt); end
    @(negedge clk);
    bus.jump = 0; bus.ex_multi = 0; bus.dbg_halt_req = 0; bus.dbg_step_req = 0;
    rst = 1;
    #1;
    total++; if ({bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush} !== 4'b1100) begin bad++; $display("FAIL run_idle got=%b want=1100", {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush}); end
  endtask

  task automatic test_jump();
    set_in(1, 0, 0, 0, 0);
    total++; if ({bus.pc_en, bus.if_id_flush, bus.id_ex_flush} !== 3'b111) begin bad++; $display("FAIL jump_c0 got=%b want=111", {bus.pc_en, bus.if_id_flush, bus.id_ex_flush}); end
    set_in(0, 1, 0, 1, 0);
    total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL jump_c1_state got=%0d want=1", bus.state); end
    total++; if ({bus.pc_en, bus.if_id_flush, bus.id_ex_flush} !== 3'b110) begin bad++; $display("FAIL jump_c1_ctl got=%b want=110", {bus.pc_en, bus.if_id_flush, bus.id_ex_flush}); end
    set_in(0, 0, 0, 0, 0);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL jump_c2_state got=%0d want=0", bus.state); end
    total++; if ({bus.if_id_flush, bus.id_ex_flush} !== 2'b00) begin bad++; $display("FAIL jump_c2_flush got=%b want=00", {bus.if_id_flush, bus.id_ex_flush}); end
  endtask

  task automatic test_multi();
    int lows;
    lows = 0;
    set_in(0, 1, 0, 0, 0);
    if (bus.pc_en === 1'b0) lows++;
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, (i == 4), 0, 0);
      if (bus.pc_en === 1'b0) lows++;
      total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL multi_wait_state got=%0d want=2", bus.state); end
    end
    total++; if (lows !== 6) begin bad++; $display("FAIL multi_stall_cycles got=%0d want=6", lows); end
    set_in(0, 0, 0, 0, 0);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL multi_back_state got=%0d want=0", bus.state); end
    total++; if (bus.stall_cnt !== 6'd6) begin bad++; $display("FAIL multi_stall_cnt got=%0d want=6", bus.stall_cnt); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL multi_timeout got=%b want=0", bus.timeout); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    set_in(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0, 0);
      if (bus.state === 3'd2) n++;
      else break;
    end
    total++; if (n !== TO + 1) begin bad++; $display("FAIL to_wait_cycles got=%0d want=%0d", n, TO + 1); end
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL to_state got=%0d want=0", bus.state); end
    total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", bus.timeout); end
    total++; if (bus.stall_cnt !== 6'd12) begin bad++; $display("FAIL to_stall got=%0d want=12", bus.stall_cnt); end
    repeat (3) set_in(1, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0);
    total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", bus.timeout); end
  endtask

  task automatic test_debug();
    set_in(0, 0, 0, 1, 0);
    total++; if ({bus.pc_en, bus.if_id_en, bus.id_ex_flush} !== 3'b001) begin bad++; $display("FAIL dbg_enter got=%b want=001", {bus.pc_en, bus.if_id_en, bus.id_ex_flush}); end
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 0, 1, 1);
      total++; if ({bus.state, bus.halted, bus.step_ack, bus.pc_en} !== {3'd3, 3'b100}) begin bad++; $display("FAIL dbg_halt%0d got=%b want=011100", k, {bus.state, bus.halted, bus.step_ack, bus.pc_en}); end
      set_in(0, 0, 0, 1, 0);
      total++; if ({bus.state, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush} !== {3'd4, 4'b1100}) begin bad++; $display("FAIL dbg_step%0d got=%b want=1001100", k, {bus.state, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush}); end
      set_in(0, 0, 0, 1, 0);
      total++; if ({bus.state, bus.step_ack, bus.halted} !== {3'd3, 2'b11}) begin bad++; $display("FAIL dbg_ack%0d got=%b want=01111", k, {bus.state, bus.step_ack, bus.halted}); end
    end
    set_in(0, 0, 0, 1, 1);
    set_in(0, 0, 0, 1, 1);
    set_in(0, 0, 0, 1, 1);
    set_in(0, 0, 0, 1, 1);
    total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL dbg_step_level got=%0d want=3", bus.state); end
    set_in(0, 0, 0, 1, 0);
    set_in(0, 0, 0, 0, 1);
    total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL dbg_release_pre got=%0d want=3", bus.state); end
    set_in(0, 0, 0, 0, 0);
    total++; if ({bus.state, bus.halted} !== 4'b0000) begin bad++; $display("FAIL dbg_release got=%b want=0000", {bus.state, bus.halted}); end
  endtask

  task automatic test_simul();
    set_in(1, 1, 0, 1, 0);
    total++; if ({bus.pc_en, bus.if_id_flush, bus.id_ex_flush} !== 3'b111) begin bad++; $display("FAIL sim_jump got=%b want=111", {bus.pc_en, bus.if_id_flush, bus.id_ex_flush}); end
    set_in(0, 1, 0, 1, 0);
    total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL sim_flush got=%0d want=1", bus.state); end
    set_in(0, 1, 0, 1, 0);
    total++; if ({bus.state, bus.pc_en, bus.id_ex_flush} !== 5'b00000) begin bad++; $display("FAIL sim_multi got=%b want=00000", {bus.state, bus.pc_en, bus.id_ex_flush}); end
    set_in(0, 0, 1, 1, 0);
    total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL sim_wait got=%0d want=2", bus.state); end
    set_in(0, 0, 0, 1, 0);
    total++; if ({bus.state, bus.pc_en, bus.id_ex_flush} !== 5'b00001) begin bad++; $display("FAIL sim_halt_req got=%b want=00001", {bus.state, bus.pc_en, bus.id_ex_flush}); end
    set_in(0, 0, 0, 0, 0);
    total++; if ({bus.state, bus.halted} !== 4'b0111) begin bad++; $display("FAIL sim_halted got=%b want=0111", {bus.state, bus.halted}); end
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    set_in(0, 1, 0, 0, 0);
    set_in(0, 0, 0, 0, 0);
    #1 rst = 0;
    #1;
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL ar_state got=%0d want=0", bus.state); end
    total++; if (bus.stall_cnt !== 6'd0) begin bad++; $display("FAIL ar_stall got=%0d want=0", bus.stall_cnt); end
    total++; if ({bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.timeout} !== 5'b00110) begin bad++; $display("FAIL ar_outs got=%b want=00110", {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.timeout}); end
    @(negedge clk);
    rst = 1;
    set_in(0, 0, 0, 1, 0);
    set_in(0, 0, 0, 1, 1);
    set_in(0, 0, 0, 1, 0);
    total++; if (bus.state !== 3'd4) begin bad++; $display("FAIL ar_in_step got=%0d want=4", bus.state); end
    #1 rst = 0;
    #1;
    total++; if ({bus.state, bus.step_ack, bus.halted} !== 5'b00000) begin bad++; $display("FAIL ar_step_abort got=%b want=00000", {bus.state, bus.step_ack, bus.halted}); end
    bus.dbg_halt_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    set_in(0, 0, 0, 0, 0);
    total++; if ({bus.state, bus.step_ack, bus.pc_en} !== 5'b00001) begin bad++; $display("FAIL ar_after got=%b want=00001", {bus.state, bus.step_ack, bus.pc_en}); end
  endtask

  task automatic test_random();
    bit j, m, d, h, s;
    h = 0;
    rst = 0;
    bus.jump = 0; bus.ex_multi = 0; bus.ex_done = 0; bus.dbg_halt_req = 0; bus.dbg_step_req = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1;
    for (int c = 0; c < 600; c++) begin
      j = ($urandom_range(0, 7) == 0);
      m = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) h = !h;
      s = ($urandom_range(0, 1) == 1);
      set_in(j, m, d, h, s);
      model_eval(j, m, d, h, s);
      total++; if ({bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush} !== {e_pc, e_pc, e_iff, e_idf}) begin bad++; $display("FAIL rnd_ctl c=%0d got=%b want=%b", c, {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush}, {e_pc, e_pc, e_iff, e_idf}); end
      total++; if (bus.state !== 3'(m_mode)) begin bad++; $display("FAIL rnd_state c=%0d got=%0d want=%0d", c, bus.state, m_mode); end
      total++; if ({bus.halted, bus.step_ack, bus.timeout} !== {m_halted, m_ack, m_to}) begin bad++; $display("FAIL rnd_flags c=%0d got=%b want=%b", c, {bus.halted, bus.step_ack, bus.timeout}, {m_halted, m_ack, m_to}); end
      total++; if (bus.stall_cnt !== CW'(m_stall)) begin bad++; $display("FAIL rnd_stall c=%0d got=%0d want=%0d", c, bus.stall_cnt, m_stall); end
      @(posedge clk);
      model_commit(d, s);
    end
  endtask

  task automatic test_saturate();
    rst = 0;
    bus.jump = 0; bus.ex_multi = 0; bus.ex_done = 0; bus.dbg_halt_req = 0; bus.dbg_step_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 70; i++) begin
      set_in(0, 0, 0, 1, 0);
      if (i == 62) begin
        total++; if (bus.stall_cnt !== 6'd62) begin bad++; $display("FAIL sat_pre got=%0d want=62", bus.stall_cnt); end
      end
    end
    set_in(0, 0, 0, 1, 0);
    total++; if (bus.stall_cnt !== 6'd63) begin bad++; $display("FAIL sat_hold got=%0d want=63", bus.stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_multi();
    test_timeout();
    test_debug();
    test_simul();
    test_async_reset();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
